mopshub_rec_arbiter: RTL and testbench

Round-robin uplink arbiter sitting between the 16 CAN bus receive channels and the single e-link uplink transmitter of MOPSHUB. Collects pending received frames from enabled buses, grants one bus at a time, drives `can_rec_select`, latches that bus's 76-bit frame into `data_rec_uplink`, and raises `irq_elink_rec` until the e-link side reports completion or a timeout. Guarantees fair service across buses and one frame in flight at a time.

---
 rtl/mopshub_rec_arbiter.sv | 149 ++++++++++++++
 tb/tb_mopshub_rec_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mopshub_rec_arbiter.sv
// Round-robin uplink arbiter: grants one pending CAN receive bus at a time to the e-link uplink.
// Optional e-link timeout abort is compiled in with `define MOPSHUB_ARB_TIMEOUT_EN.
module mopshub_rec_arbiter #(
    parameter int N_BUS          = 16,
    parameter int FRAME_W        = 76,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [4:0]               n_buses,
    input  logic [N_BUS-1:0]         bus_mask,
    input  logic [N_BUS-1:0]         req,
    input  logic [N_BUS*FRAME_W-1:0] frame_in,
    output logic [N_BUS-1:0]         ack,
    output logic [4:0]               can_rec_select,
    output logic [FRAME_W-1:0]       data_rec_uplink,
    output logic                     irq_elink_rec,
    input  logic                     elink_done,
    output logic                     busy,
    output logic                     err_timeout,
    output logic [1:0]               fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [4:0]         ptr;
    logic [3:0]         nc;
    logic [4:0]         nc_ext;
    logic [N_BUS-1:0]   elig;
    logic [4:0]         start;
    logic [4:0]         idx;
    logic               found;
    logic [4:0]         found_idx;
    logic               grab;
    logic               load;
    logic               release_grant;
    logic               abort;
    logic               tmo_hit;
    logic [FRAME_W-1:0] frames [N_BUS];

    assign nc        = (n_buses > 5'd15) ? 4'd15 : n_buses[3:0];
    assign nc_ext    = {1'b0, nc};
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    always_comb begin
        for (int i = 0; i < N_BUS; i++) begin
            frames[i] = frame_in[i*FRAME_W +: FRAME_W];
            elig[i]   = req[i] & bus_mask[i] & (4'(i) <= nc);
        end
    end

    // First eligible bus at or above ptr, wrapping past nc back to 0.
    always_comb begin
        found     = 1'b0;
        found_idx = 5'd0;
        idx       = 5'd0;
        start     = (ptr > nc_ext) ? 5'd0 : ptr;
        for (int k = 0; k < N_BUS; k++) begin
            idx = start + 5'(k);
            if (idx > nc_ext) idx = idx - (nc_ext + 5'd1);
            if (!found && (k <= int'(nc)) && elig[idx[3:0]]) begin
                found     = 1'b1;
                found_idx = idx;
            end
        end
    end

`ifdef MOPSHUB_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               tmo_cnt <= '0;
        else if (load)          tmo_cnt <= '0;
        else if (state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = (state == WAIT) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        grab          = 1'b0;
        load          = 1'b0;
        release_grant = 1'b0;
        abort         = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grab      = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                load      = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A done pulse in the same cycle as the timeout is a normal completion.
                if (elink_done) begin
                    release_grant = 1'b1;
                    state_nxt     = IDLE;
                end else if (tmo_hit) begin
                    release_grant = 1'b1;
                    abort         = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            ptr             <= 5'd0;
            can_rec_select  <= 5'd0;
            data_rec_uplink <= '0;
            ack             <= '0;
            irq_elink_rec   <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            ack         <= '0;
            err_timeout <= 1'b0;
            if (grab) can_rec_select <= found_idx;
            if (load) begin
                data_rec_uplink <= frames[can_rec_select[3:0]];
                ack             <= N_BUS'(1) << can_rec_select[3:0];
                irq_elink_rec   <= 1'b1;
            end
            if (release_grant) begin
                irq_elink_rec <= 1'b0;
                ptr           <= (can_rec_select == nc_ext) ? 5'd0 : can_rec_select + 5'd1;
                err_timeout   <= abort;
            end
        end
    end

endmodule

// File: tb/tb_mopshub_rec_arbiter.sv
// Directed bench for mopshub_rec_arbiter: grant order, masking, reset, ignored done pulses,
// and (with MOPSHUB_ARB_TIMEOUT_EN) the timeout abort path.
module tb_mopshub_rec_arbiter;

    localparam int N_BUS   = 16;
    localparam int FRAME_W = 76;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [4:0]               n_buses = 5'd15;
    logic [N_BUS-1:0]         bus_mask = '1;
    logic [N_BUS-1:0]         req = '0;
    logic [N_BUS*FRAME_W-1:0] frame_in;
    logic [N_BUS-1:0]         ack;
    logic [4:0]               can_rec_select;
    logic [FRAME_W-1:0]       data_rec_uplink;
    logic                     irq_elink_rec;
    logic                     elink_done = 1'b0;
    logic                     busy;
    logic                     err_timeout;
    logic [1:0]               fsm_state;

    int checks = 0;
    int errors = 0;

    mopshub_rec_arbiter #(
        .N_BUS(N_BUS), .FRAME_W(FRAME_W), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .n_buses(n_buses), .bus_mask(bus_mask), .req(req),
        .frame_in(frame_in), .ack(ack), .can_rec_select(can_rec_select),
        .data_rec_uplink(data_rec_uplink), .irq_elink_rec(irq_elink_rec),
        .elink_done(elink_done), .busy(busy), .err_timeout(err_timeout),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [FRAME_W-1:0] frame_of(int i);
        logic [3:0] n;
        n = 4'(i);
        return {n, 8'hC3, {16{n}} ^ 64'h0123_4567_89AB_CDEF};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_irq();
        for (int c = 0; c < 8 && !irq_elink_rec; c++) @(negedge clk);
        chk("irq_seen", 128'(irq_elink_rec), 128'd1);
    endtask

    task automatic pulse_done();
        elink_done = 1'b1;
        @(negedge clk);
        elink_done = 1'b0;
    endtask

    // Checks one grant to bus e, then completes it with done 5 cycles after irq.
    task automatic grant(input int e);
        wait_irq();
        chk("rr_sel", 128'(can_rec_select), 128'(e));
        chk("rr_ack", 128'(ack), 128'(16'(1) << e));
        chk("rr_data", 128'(data_rec_uplink), 128'(frame_of(e)));
        @(negedge clk);
        chk("rr_ack_1cyc", 128'(ack), 128'd0);
        repeat (3) @(negedge clk);
        pulse_done();
        chk("rr_irq_drop", 128'(irq_elink_rec), 128'd0);
    endtask

    initial begin
        int order[5];
        logic bad;
        order = '{0, 5, 10, 15, 0};
        for (int i = 0; i < N_BUS; i++) frame_in[i*FRAME_W +: FRAME_W] = frame_of(i);

        // Reset values
        @(negedge clk);
        chk("rst_sel", 128'(can_rec_select), 128'd0);
        chk("rst_data", 128'(data_rec_uplink), 128'd0);
        chk("rst_ack", 128'(ack), 128'd0);
        chk("rst_irq", 128'(irq_elink_rec), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_err", 128'(err_timeout), 128'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single request on bus 4: latency check
        req = 16'h0010;
        @(negedge clk);
        chk("t1_sel", 128'(can_rec_select), 128'd4);
        chk("t1_irq_early", 128'(irq_elink_rec), 128'd0);
        chk("t1_busy", 128'(busy), 128'd1);
        @(negedge clk);
        chk("t1_ack", 128'(ack), 128'h0010);
        chk("t1_irq", 128'(irq_elink_rec), 128'd1);
        chk("t1_data", 128'(data_rec_uplink), 128'(frame_of(4)));
        req = '0;
        @(negedge clk);
        chk("t1_ack_1cyc", 128'(ack), 128'd0);
        chk("t1_irq_hold", 128'(irq_elink_rec), 128'd1);
        pulse_done();
        chk("t1_irq_drop", 128'(irq_elink_rec), 128'd0);
        @(negedge clk);
        chk("t1_idle", 128'(busy), 128'd0);
        chk("t1_sel_hold", 128'(can_rec_select), 128'd4);

        // Round robin over 0,5,10,15 with n_buses above 15 (clamped)
        do_reset();
        n_buses = 5'd20;
        req = 16'h8421;
        for (int g = 0; g < 5; g++) grant(order[g]);

        // Nothing eligible: bus 4 masked, 8/9 above n_buses
        bus_mask = 16'hFFEF;
        n_buses = 5'd7;
        req = 16'h0310;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy || irq_elink_rec || (ack != '0)) bad = 1'b1;
        end
        chk("t3_no_grant", 128'(bad), 128'd0);
        chk("t3_busy", 128'(busy), 128'd0);

        // Reset during WAIT on bus 3
        bus_mask = '1;
        n_buses = 5'd15;
        req = '0;
        do_reset();
        req = 16'h0008;
        wait_irq();
        chk("t4_sel", 128'(can_rec_select), 128'd3);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t4_async_irq", 128'(irq_elink_rec), 128'd0);
        chk("t4_async_sel", 128'(can_rec_select), 128'd0);
        chk("t4_async_data", 128'(data_rec_uplink), 128'd0);
        chk("t4_async_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_regrant_sel", 128'(can_rec_select), 128'd3);
        @(negedge clk);
        chk("t4_regrant_irq", 128'(irq_elink_rec), 128'd1);
        chk("t4_regrant_ack", 128'(ack), 128'h0008);
        req = '0;
        pulse_done();

        // elink_done in IDLE and LOAD is ignored
        do_reset();
        pulse_done();
        pulse_done();
        chk("t5_idle_state", 128'(fsm_state), 128'd0);
        chk("t5_idle_irq", 128'(irq_elink_rec), 128'd0);
        req = 16'h0003;
        @(negedge clk);
        chk("t5_ptr_kept", 128'(can_rec_select), 128'd0);
        pulse_done();
        chk("t5_load_irq", 128'(irq_elink_rec), 128'd1);
        chk("t5_load_state", 128'(fsm_state), 128'd2);
        @(negedge clk);
        chk("t5_wait_hold", 128'(irq_elink_rec), 128'd1);
        pulse_done();
        chk("t5_done_drop", 128'(irq_elink_rec), 128'd0);
        wait_irq();
        chk("t5_next_sel", 128'(can_rec_select), 128'd1);
        req = '0;
        pulse_done();

`ifdef MOPSHUB_ARB_TIMEOUT_EN
        // Timeout abort 16 cycles after irq, then done on cycle 16 wins
        do_reset();
        req = 16'h0004;
        wait_irq();
        bad = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (!irq_elink_rec || err_timeout) bad = 1'b1;
        end
        chk("t6_hold", 128'(bad), 128'd0);
        @(negedge clk);
        chk("t6_irq_drop", 128'(irq_elink_rec), 128'd0);
        chk("t6_err", 128'(err_timeout), 128'd1);
        req = 16'h0006;
        @(negedge clk);
        chk("t6_err_1cyc", 128'(err_timeout), 128'd0);
        chk("t6_ptr_adv", 128'(can_rec_select), 128'd1);
        wait_irq();
        repeat (15) @(negedge clk);
        pulse_done();
        chk("t6_done_irq", 128'(irq_elink_rec), 128'd0);
        chk("t6_done_noerr", 128'(err_timeout), 128'd0);
        req = '0;
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
